// File: rtl/trigger_group.sv
// Multi-actor ap_ctrl_hs trigger controller: per-channel launch/sleep/sync
// FSMs with group-wide sleep/waited reductions and a sync-round counter.
module trigger_group #(
    parameter int NUM_ACTORS  = 4,
    parameter int RETRY_LIMIT = 2,
    parameter int ROUND_W     = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_ready,
    output logic                    ap_idle,
    input  logic [NUM_ACTORS-1:0]   actor_enable,
    output logic [NUM_ACTORS-1:0]   actor_start,
    input  logic [NUM_ACTORS-1:0]   actor_done,
    input  logic [2*NUM_ACTORS-1:0] actor_return,
    output logic [ROUND_W-1:0]      round_count
);

    localparam int CW = $clog2(RETRY_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(RETRY_LIMIT);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LAUNCH      = 3'd1;
    localparam logic [2:0] S_SLEEP       = 3'd2;
    localparam logic [2:0] S_SYNC_LAUNCH = 3'd3;
    localparam logic [2:0] S_SYNC_SLEEP  = 3'd4;

    logic [2:0]            state_q [NUM_ACTORS];
    logic [2:0]            state_d [NUM_ACTORS];
    logic [CW-1:0]         cnt_q   [NUM_ACTORS];
    logic [CW-1:0]         cnt_d   [NUM_ACTORS];
    logic [CW-1:0]         cnt_inc [NUM_ACTORS];
    logic [NUM_ACTORS-1:0] en_q;
    logic [NUM_ACTORS-1:0] is_idle;
    logic [NUM_ACTORS-1:0] is_sleep;
    logic [NUM_ACTORS-1:0] is_ssleep;
    logic [NUM_ACTORS-1:0] in_ss;
    logic [NUM_ACTORS-1:0] is_wait;
    logic [NUM_ACTORS-1:0] waited;
    logic [ROUND_W-1:0]    round_q;
    logic                  done_q;
    logic                  empty_q;

    logic grp_idle;
    logic all_sleep;
    logic all_sync_sleep;
    logic all_waited;
    logic accept;
    logic empty_start;
    logic sync_done;
    logic finish;

    always_comb begin
        for (int i = 0; i < NUM_ACTORS; i++) begin
            is_idle[i]     = state_q[i] == S_IDLE;
            is_sleep[i]    = is_idle[i] || (state_q[i] == S_SLEEP);
            in_ss[i]       = state_q[i] == S_SYNC_SLEEP;
            is_ssleep[i]   = is_idle[i] || in_ss[i];
            // Disabled channels never count against the group.
            waited[i]      = !en_q[i] || (cnt_q[i] == LIM);
            is_wait[i]     = actor_return[2*i +: 2] == 2'b01;
            cnt_inc[i]     = (cnt_q[i] == LIM) ? LIM : cnt_q[i] + 1'b1;
            actor_start[i] = (state_q[i] == S_LAUNCH) ||
                             (state_q[i] == S_SYNC_LAUNCH);
        end
    end

    assign grp_idle       = &is_idle;
    assign all_sleep      = &is_sleep;
    assign all_sync_sleep = &is_ssleep;
    assign all_waited     = &waited;
    assign accept         = ap_start && grp_idle;
    assign empty_start    = accept && !(|actor_enable);
    assign sync_done      = all_sync_sleep && (|in_ss);
    assign finish         = sync_done && all_waited;

    always_comb begin
        for (int i = 0; i < NUM_ACTORS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (accept) begin
                state_d[i] = actor_enable[i] ? S_LAUNCH : S_IDLE;
                cnt_d[i]   = '0;
            end else begin
                unique case (1'b1)
                    state_q[i] == S_IDLE: begin
                    end
                    state_q[i] == S_LAUNCH: begin
                        if (actor_done[i]) begin
                            cnt_d[i] = is_wait[i] ? cnt_inc[i] : '0;
                            if (is_wait[i] && (cnt_inc[i] == LIM))
                                state_d[i] = S_SLEEP;
                        end
                    end
                    state_q[i] == S_SLEEP: begin
                        if (all_sleep)
                            state_d[i] = S_SYNC_LAUNCH;
                        else if (!all_waited)
                            state_d[i] = S_LAUNCH;
                    end
                    state_q[i] == S_SYNC_LAUNCH: begin
                        if (actor_done[i]) begin
                            cnt_d[i]   = is_wait[i] ? cnt_inc[i] : '0;
                            state_d[i] = S_SYNC_SLEEP;
                        end
                    end
                    state_q[i] == S_SYNC_SLEEP: begin
                        if (all_sync_sleep)
                            state_d[i] = all_waited ? S_IDLE : S_LAUNCH;
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_ACTORS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            en_q    <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ACTORS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            if (accept)
                en_q <= actor_enable;
            if (accept)
                round_q <= '0;
            else if (sync_done && !(&round_q))
                round_q <= round_q + 1'b1;
            done_q  <= finish || empty_start;
            // An empty run never leaves IDLE; hold ap_idle low for its one cycle.
            empty_q <= empty_start;
        end
    end

    assign ap_done     = done_q;
    assign ap_ready    = done_q;
    assign ap_idle     = grp_idle && !empty_q;
    assign round_count = round_q;

endmodule

// File: tb/tb_trigger_group.sv
// Scoreboard bench for trigger_group: reactive actor models, directed runs,
// expected run results queued at issue and checked on each ap_done.
module tb_trigger_group;

    localparam int N = 4;

    typedef struct packed {
        logic [15:0] rnd;
        logic [3:0]  smask;
        logic [31:0] dones;
    } exp_t;

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           ap_start = 1'b0;
    logic           ap_done;
    logic           ap_ready;
    logic           ap_idle;
    logic [N-1:0]   actor_enable = '0;
    logic [N-1:0]   actor_start;
    logic [N-1:0]   actor_done = '0;
    logic [2*N-1:0] actor_return = '0;
    logic [15:0]    round_count;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         ndone = 0;
    logic [1:0] scr [N][8];
    int         slen [N];
    int         sptr [N];
    int         acnt [N];
    logic [7:0] dcnt [N];
    logic [N-1:0] sseen = '0;
    logic       prev_done = 1'b0;

    always #5 ap_clk = ~ap_clk;

    trigger_group #(
        .NUM_ACTORS (4),
        .RETRY_LIMIT(2),
        .ROUND_W    (16)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .actor_enable(actor_enable),
        .actor_start (actor_start),
        .actor_done  (actor_done),
        .actor_return(actor_return),
        .round_count (round_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Actor model: done pulse every 3rd cycle of a held start, scripted code.
    always @(negedge ap_clk) begin
        for (int i = 0; i < N; i++) begin
            if (ap_rst || !actor_start[i]) begin
                acnt[i] = 0;
                actor_done[i] = 1'b0;
            end else begin
                acnt[i]++;
                if (acnt[i] == 3) begin
                    actor_done[i] = 1'b1;
                    acnt[i] = 0;
                    actor_return[2*i +: 2] =
                        (sptr[i] < slen[i]) ? scr[i][sptr[i]] : 2'b01;
                    sptr[i]++;
                end else begin
                    actor_done[i] = 1'b0;
                end
            end
        end
    end

    always @(posedge ap_clk) begin
        for (int i = 0; i < N; i++)
            if (actor_done[i])
                dcnt[i] = dcnt[i] + 8'd1;
    end

    // Monitor: pops the expected result whenever the DUT signals completion.
    always @(negedge ap_clk) begin
        exp_t e;
        sseen = sseen | actor_start;
        if (prev_done)
            chk("done_width", {31'd0, ap_done}, 32'd0);
        if (ap_done) begin
            ndone++;
            chk("ready_eq_done", {31'd0, ap_ready}, 32'd1);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got ap_done=1 expected no run");
            end else begin
                e = sbq.pop_front();
                chk("round_count", {16'd0, round_count}, {16'd0, e.rnd});
                chk("start_mask", {28'd0, sseen}, {28'd0, e.smask});
                chk("done_counts", {dcnt[3], dcnt[2], dcnt[1], dcnt[0]}, e.dones);
            end
        end
        prev_done = ap_done;
    end

    task automatic run(input logic [3:0] mask, input logic [15:0] rnd,
                       input logic [31:0] dones);
        exp_t e;
        int   seen;
        bit   ok;
        e.rnd = rnd;
        e.smask = mask;
        e.dones = dones;
        sbq.push_back(e);
        @(negedge ap_clk);
        for (int i = 0; i < N; i++) begin
            dcnt[i] = 8'd0;
            sptr[i] = 0;
        end
        sseen = '0;
        seen = ndone;
        actor_enable = mask;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("start_rise", {28'd0, actor_start}, {28'd0, mask});
        chk("idle_low", {31'd0, ap_idle}, 32'd0);
        if (mask == 4'd0)
            chk("empty_done", {31'd0, ap_done}, 32'd1);
        ap_start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge ap_clk);
            if (ndone != seen) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got no ap_done expected done for mask %b", mask);
            void'(sbq.pop_front());
            ap_rst = 1'b1;
            @(negedge ap_clk);
            ap_rst = 1'b0;
        end
        @(negedge ap_clk);
        chk("idle_after", {31'd0, ap_idle}, 32'd1);
        for (int i = 0; i < N; i++)
            slen[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            slen[i] = 0;
            sptr[i] = 0;
            acnt[i] = 0;
            dcnt[i] = 8'd0;
        end
        #2;
        chk("rst_idle", {31'd0, ap_idle}, 32'd1);
        chk("rst_done", {31'd0, ap_done}, 32'd0);
        chk("rst_ready", {31'd0, ap_ready}, 32'd0);
        chk("rst_start", {28'd0, actor_start}, 32'd0);
        chk("rst_round", {16'd0, round_count}, 32'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // Two channels, all WAIT: 2 launch dones + 1 sync done each.
        run(4'b0011, 16'd1, 32'h0000_0303);

        // WAIT, progress, WAIT, WAIT: sleeps only after the 4th done.
        scr[0][0] = 2'b01;
        scr[0][1] = 2'b00;
        scr[0][2] = 2'b01;
        scr[0][3] = 2'b01;
        slen[0] = 4;
        run(4'b0001, 16'd1, 32'h0000_0005);

        // Channel 1 reports progress in the sync phase: second pass needed.
        scr[1][0] = 2'b01;
        scr[1][1] = 2'b01;
        scr[1][2] = 2'b00;
        slen[1] = 3;
        run(4'b0011, 16'd2, 32'h0000_0606);

        run(4'b0101, 16'd1, 32'h0003_0003);

        run(4'b0000, 16'd0, 32'h0000_0000);

        // Reset while channels are launching.
        @(negedge ap_clk);
        actor_enable = 4'b0011;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (2) @(posedge ap_clk);
        #3;
        chk("pre_rst_start", {28'd0, actor_start}, 32'h3);
        ap_rst = 1'b1;
        #1;
        chk("rst_async_start", {28'd0, actor_start}, 32'd0);
        chk("rst_async_idle", {31'd0, ap_idle}, 32'd1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("post_rst_idle", {31'd0, ap_idle}, 32'd1);
        chk("post_rst_round", {16'd0, round_count}, 32'd0);
        chk("post_rst_done", {31'd0, ap_done}, 32'd0);

        run(4'b0011, 16'd1, 32'h0000_0303);

        repeat (3) @(negedge ap_clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_group.md
# trigger_group

Parametrised multi-actor trigger controller for the Vivado HLS platform. It drives NUM_ACTORS ap_ctrl_hs actor instances from one network-level ap_start/ap_done handshake. Per-actor launch/sleep/sync FSMs, the group-wide sleep and waited reductions, and a configurable WAIT-retry budget are all internal. It replaces per-actor trigger instances plus external AND trees. It adds a per-run enable mask, a registered done pulse and a sync-round counter.

## Interface
- NUM_ACTORS, 4: number of actor channels; must be ≥ 1.
- RETRY_LIMIT, 2: consecutive WAIT returns an actor needs before it may sleep; must be ≥ 1.
- ROUND_W, 16: width of the sync-round counter.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  run request; accepted only when the group is idle.
- ap_done  out  1  one-cycle registered pulse at end of run.
- ap_ready  out  1  identical to ap_done.
- ap_idle  out  1  high when every channel is in IDLE.
- actor_enable  in  NUM_ACTORS  per-channel enable; sampled when ap_start is accepted.
- actor_start  out  NUM_ACTORS  per-channel ap_start, level-held.
- actor_done  in  NUM_ACTORS  per-channel ap_done.
- actor_return  in  2*NUM_ACTORS  per-channel return code; bits [2i+1:2i] belong to channel i; 2'b01 = WAIT, any other value = progress.
- round_count  out  ROUND_W  number of sync phases completed in the current or last run; saturating.

## Operation
- Per-channel state set: IDLE, LAUNCH, SLEEP, SYNC_LAUNCH, SYNC_SLEEP.
- Per-channel wait counter:
  - Width $clog2(RETRY_LIMIT+1); saturates at RETRY_LIMIT.
  - On actor_done with WAIT: counter increments (saturating). On actor_done with progress: counter clears.
  - waited_i = (counter == RETRY_LIMIT).
- A disabled channel stays in IDLE for the whole run. It counts as sleeping, sync-sleeping and waited in all reductions.
- Reductions, computed combinationally from registered state:
  - all_sleep = AND over enabled channels of (state ∈ {SLEEP, IDLE}).
  - all_sync_sleep = AND of (state ∈ {SYNC_SLEEP, IDLE}).
  - all_waited = AND of waited_i.
- Start of run: when the group is idle and ap_start = 1:
  - Latch actor_enable.
  - Clear round_count and all wait counters.
  - Every enabled channel moves IDLE→LAUNCH.
- LAUNCH:
  - actor_done with WAIT and an incremented count reaching RETRY_LIMIT → SLEEP.
  - Any other case stays in LAUNCH, and actor_start stays high so the actor is relaunched.
- SLEEP, in priority order:
  - all_sleep → SYNC_LAUNCH.
  - Else !all_waited → LAUNCH.
  - Else stay in SLEEP.
- SYNC_LAUNCH: actor_done → SYNC_SLEEP; the wait counter updates as in LAUNCH.
- SYNC_SLEEP: when all_sync_sleep holds:
  - If all_waited, go to IDLE.
  - Otherwise go to LAUNCH.
  - round_count increments (saturating at 2^ROUND_W−1) in both cases.
  - Otherwise stay in SYNC_SLEEP.
- actor_start[i] = state_i ∈ {LAUNCH, SYNC_LAUNCH}, decoded combinationally from the state register.
- ap_done/ap_ready register to 1 on the edge where the group returns to IDLE, and are 0 on every other cycle.
- A start with an all-zero enable mask completes immediately: ap_done pulses one cycle after acceptance.
- ap_start while not idle is ignored. It is not queued.
- An unused or illegal state encoding recovers to IDLE.

## Timing
- Reset values:
  - All channel states IDLE.
  - Wait counters 0; round_count 0; enable latch 0.
  - ap_done 0, ap_ready 0, ap_idle 1, actor_start all 0.
- Asserting ap_rst mid-run deasserts actor_start within the same cycle, asynchronously, because outputs are decoded from the reset state register.
- ap_start accepted at edge t → actor_start high in cycle t+1; ap_idle low in cycle t+1.
- actor_done sampled at edge t → state change visible in cycle t+1.
- Last channel enters SYNC_SLEEP in cycle t with all_waited = 1 → states are IDLE and ap_done = 1 in cycle t+1 → ap_done = 0 in cycle t+2.
- New ap_start is accepted in the same cycle ap_done is high, because the group is already idle.
- Simultaneous actor_done across channels is legal. All counters and states update on the same edge.

## Test plan
- NUM_ACTORS=2, RETRY_LIMIT=1, both enabled. Each actor returns WAIT on every done (first done 3 cycles after its start rises) → both reach SLEEP, then SYNC_LAUNCH, then SYNC_SLEEP → IDLE. Required: ap_done one cycle, round_count = 1.
- RETRY_LIMIT=2, one actor: returns WAIT, progress, WAIT, WAIT → stays in LAUNCH for 4 dones (counter 1, 0, 1, 2) and enters SLEEP only after the 4th.
- Two actors: actor0 sleeps while actor1 returns progress during the sync phase → after all_sync_sleep both return to LAUNCH, round_count = 1. A second clean sync pass → IDLE, round_count = 2.
- actor_enable = 4'b0101 with NUM_ACTORS=4 → actor_start[1] and actor_start[3] never rise. Run completes with channels 0 and 2 only.
- actor_enable = 0, ap_start for one cycle → ap_done at t+1, no actor_start activity, ap_idle stays high except at t+1.
- ap_rst asserted while in LAUNCH, between clock edges → actor_start low immediately. After release: ap_idle = 1, round_count = 0, and the next run behaves as from power-up.
